// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port-0 arbiter: read latency, requester count,
// requester id and the read-tag record carried down the response pipeline.
package sram_arb_pkg;

  localparam int unsigned READ_LAT = 3;
  localparam int unsigned NREQ     = 2;

  typedef logic req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/sram_port0_arbiter_if.sv
// Requester-side bus of the SRAM port-0 arbiter: two valid/ready request channels and two
// read-response channels. The arbiter takes the slave modport, the requesters the master.
interface sram_port0_arbiter_if #(
  parameter int unsigned ASIZE = 4,
  parameter int unsigned DSIZE = 8
);

  logic             req0_valid;
  logic             req0_ready;
  logic             req0_we;
  logic [ASIZE-1:0] req0_addr;
  logic [DSIZE-1:0] req0_wdata;
  logic             req1_valid;
  logic             req1_ready;
  logic             req1_we;
  logic [ASIZE-1:0] req1_addr;
  logic [DSIZE-1:0] req1_wdata;
  logic             rsp0_valid;
  logic [DSIZE-1:0] rsp0_rdata;
  logic             rsp1_valid;
  logic [DSIZE-1:0] rsp1_rdata;

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata
  );

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata
  );

endinterface

// File: rtl/sram_port0_arbiter_rr_arbiter2.sv
// Two-way grant logic. With SRAM_ARB_RR_EN defined it is round-robin over a registered
// last-grant pointer; otherwise requester 0 has fixed priority and no state exists.
module rr_arbiter2
  import sram_arb_pkg::*;
(
`ifdef SRAM_ARB_RR_EN
  input  logic            clk,
  input  logic            rst_n,
`endif
  input  logic [NREQ-1:0] valid_i,
  output logic [NREQ-1:0] gnt_o
);

`ifdef SRAM_ARB_RR_EN
  req_id_t last_q, last_d;

  always_comb begin
    gnt_o = valid_i;
    if (valid_i == 2'b11) begin
      gnt_o = last_q ? 2'b01 : 2'b10;
    end
  end

  // Any grant is an accept because grants only go to valid requesters.
  always_comb begin
    last_d = last_q;
    if (gnt_o[1]) begin
      last_d = 1'b1;
    end else if (gnt_o[0]) begin
      last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign gnt_o = {valid_i[1] & ~valid_i[0], valid_i[0]};
`endif

endmodule

// File: rtl/sram_port0_arbiter.sv
// Arbiter/sequencer for the R/W port of the dual-port SRAM: one registered command per cycle
// and a tag pipeline that routes each read back to its requester. Policy macro: SRAM_ARB_RR_EN.
module sram_port0_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ASIZE = 4,
  parameter int unsigned DSIZE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  sram_port0_arbiter_if.slave bus,
  output logic             sram_cs0_n,
  output logic             sram_we0_n,
  output logic [ASIZE-1:0] sram_addr0,
  output logic [DSIZE-1:0] sram_wdata0,
  input  logic [DSIZE-1:0] sram_rdata0,
  output logic             busy
);

  logic [NREQ-1:0] gnt;
  logic            accept;
  logic            sel_we;
  logic [ASIZE-1:0] sel_addr;
  logic [DSIZE-1:0] sel_wdata;

  logic             cs_n_q, cs_n_d;
  logic             we_n_q, we_n_d;
  logic [ASIZE-1:0] addr_q, addr_d;
  logic [DSIZE-1:0] wdata_q, wdata_d;
  tag_t [READ_LAT-1:0] tag_q, tag_d;

  rr_arbiter2 u_arb (
`ifdef SRAM_ARB_RR_EN
    .clk     (clk),
    .rst_n   (rst_n),
`endif
    .valid_i ({bus.req1_valid, bus.req0_valid}),
    .gnt_o   (gnt)
  );

  // Ready is held low during reset even though grant logic is purely combinational.
  assign bus.req0_ready = gnt[0] & rst_n;
  assign bus.req1_ready = gnt[1] & rst_n;
  assign accept         = |gnt;

  always_comb begin
    sel_we    = bus.req0_we;
    sel_addr  = bus.req0_addr;
    sel_wdata = bus.req0_wdata;
    if (gnt[1]) begin
      sel_we    = bus.req1_we;
      sel_addr  = bus.req1_addr;
      sel_wdata = bus.req1_wdata;
    end
  end

  always_comb begin
    cs_n_d  = ~accept;
    we_n_d  = ~(accept & sel_we);
    addr_d  = accept ? sel_addr  : addr_q;
    wdata_d = accept ? sel_wdata : wdata_q;
    tag_d[0].valid = accept & ~sel_we;
    tag_d[0].id    = gnt[1];
    for (int i = 1; i < READ_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      tag_q   <= '0;
    end else begin
      cs_n_q  <= cs_n_d;
      we_n_q  <= we_n_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tag_q   <= tag_d;
    end
  end

  assign sram_cs0_n  = cs_n_q;
  assign sram_we0_n  = we_n_q;
  assign sram_addr0  = addr_q;
  assign sram_wdata0 = wdata_q;

  assign bus.rsp0_valid = tag_q[READ_LAT-1].valid & ~tag_q[READ_LAT-1].id;
  assign bus.rsp1_valid = tag_q[READ_LAT-1].valid &  tag_q[READ_LAT-1].id;
  assign bus.rsp0_rdata = sram_rdata0;
  assign bus.rsp1_rdata = sram_rdata0;

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < READ_LAT; i++) begin
      busy = busy | tag_q[i].valid;
    end
  end

endmodule
